// File: rtl/pipe_ctrl_sequencer_pkg.sv
// Shared types for the pipeline control sequencer.
//   seq_state_e    : sequencer FSM states (3-bit encoding)
//   run_req_e      : winning request in RUN after priority resolution
//   decode_run_req : fixed priority mem stall > flush > RAW stall > halt
package pipe_ctrl_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_RUN      = 3'd0,
        ST_MEM_WAIT = 3'd1,
        ST_FLUSH    = 3'd2,
        ST_DRAIN    = 3'd3,
        ST_HALTED   = 3'd4,
        ST_ERROR    = 3'd5
    } seq_state_e;

    typedef enum logic [2:0] {
        REQ_NONE  = 3'd0,
        REQ_MEM   = 3'd1,
        REQ_FLUSH = 3'd2,
        REQ_RAW   = 3'd3,
        REQ_HALT  = 3'd4
    } run_req_e;

    // A memory access acknowledged in the same cycle it is requested does not
    // stall, so the lower-priority requests are still considered.
    function automatic run_req_e decode_run_req(
        input logic mem_req_e,
        input logic mem_ack,
        input logic ctrl_flush,
        input logic raw_stall,
        input logic halt_req
    );
        if (mem_req_e && !mem_ack) return REQ_MEM;
        if (ctrl_flush)            return REQ_FLUSH;
        if (raw_stall)             return REQ_RAW;
        if (halt_req)              return REQ_HALT;
        return REQ_NONE;
    endfunction

endpackage

// File: rtl/pipe_ctrl_sequencer_if.sv
// Request/strobe bundle between the hazard unit, data memory and the sequencer.
//   requests : raw_stall, ctrl_flush, mem_req_E, mem_ack, halt_req, resume
//   strobes  : en_FD, en_DE, en_EW, clr_FD, clr_DE, halted, mem_err
//   counters : stall_cnt, flush_cnt (CNT_W bits)
//   master   : drives requests (hazard unit / memory side)
//   slave    : the sequencer, drives strobes and counters
interface pipe_ctrl_sequencer_if #(
    parameter int unsigned CNT_W = 16
);
    logic             raw_stall;
    logic             ctrl_flush;
    logic             mem_req_E;
    logic             mem_ack;
    logic             halt_req;
    logic             resume;
    logic             en_FD;
    logic             en_DE;
    logic             en_EW;
    logic             clr_FD;
    logic             clr_DE;
    logic             halted;
    logic             mem_err;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    modport master (
        output raw_stall, ctrl_flush, mem_req_E, mem_ack, halt_req, resume,
        input  en_FD, en_DE, en_EW, clr_FD, clr_DE, halted, mem_err,
        input  stall_cnt, flush_cnt
    );

    modport slave (
        input  raw_stall, ctrl_flush, mem_req_E, mem_ack, halt_req, resume,
        output en_FD, en_DE, en_EW, clr_FD, clr_DE, halted, mem_err,
        output stall_cnt, flush_cnt
    );
endinterface

// File: rtl/pipe_ctrl_sequencer_sat_counter.sv
// Saturating up-counter used for the performance counters.
//   clk, rst : clock, asynchronous active-high reset (clears q)
//   inc      : count this cycle; caller must hold it low while saturate=1
//   q        : count value
//   saturate : q is at its maximum (all ones)
module sat_counter #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] q,
    output logic         saturate
);
    assign saturate = &q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '0;
        end else if (inc) begin
            q <= q + 1'b1;
        end
    end
endmodule

// File: rtl/pipe_ctrl_sequencer.sv
// Pipeline control sequencer: merges RAW stall, control flush, the data-memory
// req/ack handshake and HLT into per-register enable/clear strobes for the
// FD/DE/EW pipeline registers. Strobes are combinational from state+requests.
//   clk, rst : pipeline clock, asynchronous active-high reset
//   bus      : slave side of pipe_ctrl_sequencer_if (requests in, strobes,
//              halted, mem_err and the stall/flush counters out)
module pipe_ctrl_sequencer
    import pipe_ctrl_sequencer_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT  = 16,
    parameter int unsigned FLUSH_CYCLES = 1,
    parameter int unsigned DRAIN_DEPTH  = 2,
    parameter int unsigned CNT_W        = 16
) (
    input logic                  clk,
    input logic                  rst,
    pipe_ctrl_sequencer_if.slave bus
);
    // One timer serves MEM_WAIT, FLUSH and DRAIN, so size it for the largest.
    localparam int unsigned TMAX_A = (MEM_TIMEOUT > FLUSH_CYCLES) ? MEM_TIMEOUT : FLUSH_CYCLES;
    localparam int unsigned TMAX   = (TMAX_A > DRAIN_DEPTH) ? TMAX_A : DRAIN_DEPTH;
    localparam int unsigned TW     = $clog2(TMAX + 1);
    localparam logic [TW-1:0] T_MEM_END   = TW'(MEM_TIMEOUT);
    localparam logic [TW-1:0] T_FLUSH_END = TW'(FLUSH_CYCLES - 1);
    localparam logic [TW-1:0] T_DRAIN_END = TW'(DRAIN_DEPTH - 1);

    seq_state_e    state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    run_req_e      run_req;
    logic          en_fd, en_de, en_ew, clr_fd, clr_de, halted;
    logic          stall_inc, flush_inc, stall_sat, flush_sat;

    assign run_req = decode_run_req(bus.mem_req_E, bus.mem_ack, bus.ctrl_flush,
                                    bus.raw_stall, bus.halt_req);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_RUN;
            timer_q <= '0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        en_fd     = 1'b1;
        en_de     = 1'b1;
        en_ew     = 1'b1;
        clr_fd    = 1'b0;
        clr_de    = 1'b0;
        halted    = 1'b0;
        flush_inc = 1'b0;
        case (state_q)
            ST_RUN: begin
                case (run_req)
                    REQ_MEM: begin
                        {en_fd, en_de, en_ew} = '0;
                        state_d = ST_MEM_WAIT;
                        timer_d = TW'(1);
                    end
                    REQ_FLUSH: begin
                        {clr_fd, clr_de} = '1;
                        flush_inc = 1'b1;
                        if (FLUSH_CYCLES > 1) begin
                            state_d = ST_FLUSH;
                            timer_d = TW'(1);
                        end
                    end
                    REQ_RAW: begin
                        {en_fd, en_de} = '0;
                        clr_de = 1'b1;
                    end
                    REQ_HALT: begin
                        en_fd  = 1'b0;
                        clr_de = 1'b1;
                        // This cycle is the first drain bubble.
                        if (DRAIN_DEPTH > 1) begin
                            state_d = ST_DRAIN;
                            timer_d = TW'(1);
                        end else begin
                            state_d = ST_HALTED;
                        end
                    end
                    default: ;
                endcase
            end
            ST_MEM_WAIT: begin
                if (bus.mem_ack) begin
                    state_d = ST_RUN;
                end else begin
                    {en_fd, en_de, en_ew} = '0;
                    if (timer_q == T_MEM_END) state_d = ST_ERROR;
                    else                      timer_d = timer_q + TW'(1);
                end
            end
            ST_FLUSH: begin
                {clr_fd, clr_de} = '1;
                if (bus.ctrl_flush) begin
                    flush_inc = 1'b1;
                    timer_d   = TW'(1);
                end else if (timer_q >= T_FLUSH_END) begin
                    state_d = ST_RUN;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            ST_DRAIN: begin
                en_fd  = 1'b0;
                clr_de = 1'b1;
                if (timer_q >= T_DRAIN_END) state_d = ST_HALTED;
                else                        timer_d = timer_q + TW'(1);
            end
            ST_HALTED: begin
                {en_fd, en_de, en_ew} = '0;
                halted = 1'b1;
                if (bus.resume) state_d = ST_RUN;
            end
            ST_ERROR: begin
                {en_fd, en_de, en_ew} = '0;
            end
            default: state_d = ST_RUN;
        endcase
        stall_inc = !en_fd && (state_q == ST_RUN || state_q == ST_MEM_WAIT);
        // Reset overrides everything: freeze and bubble all registers.
        if (rst) begin
            {en_fd, en_de, en_ew} = '0;
            {clr_fd, clr_de}      = '1;
            halted                = 1'b0;
            stall_inc             = 1'b0;
            flush_inc             = 1'b0;
        end
    end

    assign bus.en_FD   = en_fd;
    assign bus.en_DE   = en_de;
    assign bus.en_EW   = en_ew;
    assign bus.clr_FD  = clr_fd;
    assign bus.clr_DE  = clr_de;
    assign bus.halted  = halted;
    assign bus.mem_err = (state_q == ST_ERROR);

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk      (clk),
        .rst      (rst),
        .inc      (stall_inc && !stall_sat),
        .q        (bus.stall_cnt),
        .saturate (stall_sat)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk      (clk),
        .rst      (rst),
        .inc      (flush_inc && !flush_sat),
        .q        (bus.flush_cnt),
        .saturate (flush_sat)
    );
endmodule

// File: tb/tb_pipe_ctrl_sequencer.sv
// Directed testbench for pipe_ctrl_sequencer: default-parameter instance plus a
// CNT_W=4 instance for counter saturation. Inputs change on the falling edge;
// combinational strobes are sampled 1 ns later, registered results one cycle on.
// Strobe vector order: {en_FD, en_DE, en_EW, clr_FD, clr_DE, halted, mem_err}.
module tb_pipe_ctrl_sequencer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rst4 = 1'b1;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    pipe_ctrl_sequencer_if #(.CNT_W(16)) b ();
    pipe_ctrl_sequencer_if #(.CNT_W(4))  b4 ();

    pipe_ctrl_sequencer #(.MEM_TIMEOUT(16), .FLUSH_CYCLES(1), .DRAIN_DEPTH(2), .CNT_W(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (b.slave)
    );

    pipe_ctrl_sequencer #(.MEM_TIMEOUT(16), .FLUSH_CYCLES(1), .DRAIN_DEPTH(2), .CNT_W(4)) dut4 (
        .clk (clk),
        .rst (rst4),
        .bus (b4.slave)
    );

    logic [6:0] strb, strb4;
    assign strb  = {b.en_FD, b.en_DE, b.en_EW, b.clr_FD, b.clr_DE, b.halted, b.mem_err};
    assign strb4 = {b4.en_FD, b4.en_DE, b4.en_EW, b4.clr_FD, b4.clr_DE, b4.halted, b4.mem_err};

    localparam logic [6:0] S_RUN   = 7'b1110000;
    localparam logic [6:0] S_RST   = 7'b0001100;
    localparam logic [6:0] S_FRZ   = 7'b0000000;
    localparam logic [6:0] S_RAW   = 7'b0010100;
    localparam logic [6:0] S_FLUSH = 7'b1111100;
    localparam logic [6:0] S_DRAIN = 7'b0110100;
    localparam logic [6:0] S_HALT  = 7'b0000010;
    localparam logic [6:0] S_ERR   = 7'b0000001;

    task automatic sample();
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        sample();
        sample();
        checks++; if (strb !== S_RST) begin failures++; $display("FAIL reset_strobes got=%b exp=%b", strb, S_RST); end
        checks++; if (b.stall_cnt !== 16'd0) begin failures++; $display("FAIL reset_stall_cnt got=%0d exp=0", b.stall_cnt); end
        checks++; if (b.flush_cnt !== 16'd0) begin failures++; $display("FAIL reset_flush_cnt got=%0d exp=0", b.flush_cnt); end
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++; if (strb !== S_RUN) begin failures++; $display("FAIL reset_release_run got=%b exp=%b", strb, S_RUN); end
    endtask

    task automatic test_raw_stall();
        @(negedge clk);
        b.raw_stall = 1'b1;
        #1;
        checks++; if (strb !== S_RAW) begin failures++; $display("FAIL raw_strobes got=%b exp=%b", strb, S_RAW); end
        @(negedge clk);
        b.raw_stall = 1'b0;
        #1;
        checks++; if (strb !== S_RUN) begin failures++; $display("FAIL raw_after got=%b exp=%b", strb, S_RUN); end
        checks++; if (b.stall_cnt !== 16'd1) begin failures++; $display("FAIL raw_stall_cnt got=%0d exp=1", b.stall_cnt); end
    endtask

    task automatic test_flush_over_raw();
        do_reset();
        @(negedge clk);
        b.raw_stall  = 1'b1;
        b.ctrl_flush = 1'b1;
        #1;
        checks++; if (strb !== S_FLUSH) begin failures++; $display("FAIL flush_strobes got=%b exp=%b", strb, S_FLUSH); end
        @(negedge clk);
        b.raw_stall  = 1'b0;
        b.ctrl_flush = 1'b0;
        #1;
        checks++; if (strb !== S_RUN) begin failures++; $display("FAIL flush_back_run got=%b exp=%b", strb, S_RUN); end
        checks++; if (b.flush_cnt !== 16'd1) begin failures++; $display("FAIL flush_cnt got=%0d exp=1", b.flush_cnt); end
        checks++; if (b.stall_cnt !== 16'd0) begin failures++; $display("FAIL flush_stall_cnt got=%0d exp=0", b.stall_cnt); end
    endtask

    task automatic test_mem_ack();
        do_reset();
        @(negedge clk);
        b.mem_req_E = 1'b1;
        #1;
        checks++; if (strb !== S_FRZ) begin failures++; $display("FAIL mem_req_run got=%b exp=%b", strb, S_FRZ); end
        for (int i = 1; i < 3; i++) begin
            sample();
            checks++; if (strb !== S_FRZ) begin failures++; $display("FAIL mem_wait_%0d got=%b exp=%b", i, strb, S_FRZ); end
        end
        @(negedge clk);
        b.mem_ack = 1'b1;
        #1;
        checks++; if (strb !== S_RUN) begin failures++; $display("FAIL mem_ack_cycle got=%b exp=%b", strb, S_RUN); end
        @(negedge clk);
        b.mem_ack = 1'b0;
        b.mem_req_E = 1'b0;
        #1;
        checks++; if (strb !== S_RUN) begin failures++; $display("FAIL mem_after_ack got=%b exp=%b", strb, S_RUN); end
        checks++; if (b.stall_cnt !== 16'd3) begin failures++; $display("FAIL mem_stall_cnt got=%0d exp=3", b.stall_cnt); end
        // Request acknowledged in the same cycle: no stall.
        @(negedge clk);
        b.mem_req_E = 1'b1;
        b.mem_ack   = 1'b1;
        #1;
        checks++; if (strb !== S_RUN) begin failures++; $display("FAIL mem_same_cycle got=%b exp=%b", strb, S_RUN); end
        @(negedge clk);
        b.mem_req_E = 1'b0;
        b.mem_ack   = 1'b0;
        #1;
        checks++; if (b.stall_cnt !== 16'd3) begin failures++; $display("FAIL mem_same_cnt got=%0d exp=3", b.stall_cnt); end
    endtask

    task automatic test_mem_timeout();
        do_reset();
        @(negedge clk);
        b.mem_req_E = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            sample();
            checks++; if (strb !== S_FRZ) begin failures++; $display("FAIL timeout_wait_%0d got=%b exp=%b", i, strb, S_FRZ); end
        end
        sample();
        checks++; if (strb !== S_ERR) begin failures++; $display("FAIL timeout_error got=%b exp=%b", strb, S_ERR); end
        b.mem_req_E = 1'b0;
        b.mem_ack   = 1'b1;
        repeat (3) sample();
        b.mem_ack = 1'b0;
        checks++; if (strb !== S_ERR) begin failures++; $display("FAIL timeout_sticky got=%b exp=%b", strb, S_ERR); end
        checks++; if (b.stall_cnt !== 16'd17) begin failures++; $display("FAIL timeout_stall_cnt got=%0d exp=17", b.stall_cnt); end
        do_reset();
        #1;
        checks++; if (strb !== S_RUN) begin failures++; $display("FAIL timeout_cleared got=%b exp=%b", strb, S_RUN); end
    endtask

    task automatic test_halt();
        do_reset();
        @(negedge clk);
        b.halt_req = 1'b1;
        #1;
        checks++; if (strb !== S_DRAIN) begin failures++; $display("FAIL halt_first got=%b exp=%b", strb, S_DRAIN); end
        @(negedge clk);
        b.halt_req   = 1'b0;
        b.ctrl_flush = 1'b1;  // must be ignored while draining
        #1;
        checks++; if (strb !== S_DRAIN) begin failures++; $display("FAIL halt_drain got=%b exp=%b", strb, S_DRAIN); end
        @(negedge clk);
        b.ctrl_flush = 1'b0;
        #1;
        checks++; if (strb !== S_HALT) begin failures++; $display("FAIL halt_halted got=%b exp=%b", strb, S_HALT); end
        checks++; if (b.flush_cnt !== 16'd0) begin failures++; $display("FAIL halt_flush_cnt got=%0d exp=0", b.flush_cnt); end
        sample();
        checks++; if (strb !== S_HALT) begin failures++; $display("FAIL halt_hold got=%b exp=%b", strb, S_HALT); end
        @(negedge clk);
        b.resume = 1'b1;
        #1;
        checks++; if (strb !== S_HALT) begin failures++; $display("FAIL halt_resume_cycle got=%b exp=%b", strb, S_HALT); end
        @(negedge clk);
        b.resume = 1'b0;
        #1;
        checks++; if (strb !== S_RUN) begin failures++; $display("FAIL halt_resumed got=%b exp=%b", strb, S_RUN); end
        checks++; if (b.stall_cnt !== 16'd1) begin failures++; $display("FAIL halt_stall_cnt got=%0d exp=1", b.stall_cnt); end
    endtask

    task automatic test_saturate();
        @(negedge clk);
        rst4 = 1'b0;
        b4.raw_stall = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            #1;
            if (i == 15) begin
                checks++; if (b4.stall_cnt !== 4'd15) begin failures++; $display("FAIL sat_stall_15 got=%0d exp=15", b4.stall_cnt); end
            end
        end
        checks++; if (b4.stall_cnt !== 4'd15) begin failures++; $display("FAIL sat_stall_20 got=%0d exp=15", b4.stall_cnt); end
        b4.raw_stall  = 1'b0;
        b4.ctrl_flush = 1'b1;
        repeat (17) sample();
        b4.ctrl_flush = 1'b0;
        checks++; if (b4.flush_cnt !== 4'd15) begin failures++; $display("FAIL sat_flush_17 got=%0d exp=15", b4.flush_cnt); end
        b4.mem_req_E = 1'b1;
        sample();
        sample();
        checks++; if (strb4 !== S_FRZ) begin failures++; $display("FAIL sat_mem_wait got=%b exp=%b", strb4, S_FRZ); end
        rst4 = 1'b1;
        #1;
        checks++; if (strb4 !== S_RST) begin failures++; $display("FAIL sat_rst_strobes got=%b exp=%b", strb4, S_RST); end
        checks++; if (b4.stall_cnt !== 4'd0 || b4.flush_cnt !== 4'd0) begin
            failures++; $display("FAIL sat_rst_counters got=%0d/%0d exp=0/0", b4.stall_cnt, b4.flush_cnt);
        end
        @(negedge clk);
        b4.mem_req_E = 1'b0;
        rst4 = 1'b0;
        #1;
        checks++; if (strb4 !== S_RUN) begin failures++; $display("FAIL sat_rst_run got=%b exp=%b", strb4, S_RUN); end
    endtask

    initial begin
        {b.raw_stall, b.ctrl_flush, b.mem_req_E, b.mem_ack, b.halt_req, b.resume} = '0;
        {b4.raw_stall, b4.ctrl_flush, b4.mem_req_E, b4.mem_ack, b4.halt_req, b4.resume} = '0;
        test_reset();
        test_raw_stall();
        test_flush_over_raw();
        test_mem_ack();
        test_mem_timeout();
        test_halt();
        test_saturate();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
